// File: rtl/digital_lock_pkg.sv
// Shared definitions for the digital lock: chord state encoding and default timing.
package digital_lock_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    CHORD        = 2'd1,
    EMIT         = 2'd2,
    WAIT_RELEASE = 2'd3
  } chord_state_t;

  localparam int CLOCK_HZ    = 50_000_000;
  localparam int DEBOUNCE_MS = 10;
  localparam int MAX_HOLD_MS = 2000;

  localparam int DEFAULT_DEBOUNCE_CYCLES = (CLOCK_HZ / 1000) * DEBOUNCE_MS;
  localparam int DEFAULT_MAX_HOLD_CYCLES = (CLOCK_HZ / 1000) * MAX_HOLD_MS;

endpackage

// File: rtl/key_debounce.sv
// One push-button: two-flop synchroniser on the active-low pin, then a stability counter.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clock,
  input  logic reset,
  input  logic key_n,
  output logic key_held
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;
  logic          pressed;

  assign pressed = ~sync2;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      key_held <= 1'b0;
      cnt      <= '0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      // Any disagreement shorter than DEBOUNCE_CYCLES restarts the count.
      if (pressed == key_held) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        key_held <= pressed;
        cnt      <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_chord_conditioner.sv
// Debounces the push-buttons and turns each chord (first press to full release) into one key event.
//   state        | meaning
//   IDLE         | no button held, waiting for first debounced press
//   CHORD        | accumulating pressed buttons into the mask, hold timer running
//   EMIT         | key/key_strobe presented for this one cycle
//   WAIT_RELEASE | chord aborted for over-long hold, waiting for all buttons up
module key_chord_conditioner
  import digital_lock_pkg::*;
#(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int MAX_HOLD_CYCLES = DEFAULT_MAX_HOLD_CYCLES
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] key,
  output logic                key_strobe,
  output logic [NUM_KEYS-1:0] key_held,
  output logic                chord_active,
  output logic                long_press
);

  localparam int HW = $clog2(MAX_HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD_CYCLES - 1);

  chord_state_t        state;
  logic [NUM_KEYS-1:0] mask;
  logic [HW-1:0]       hold_cnt;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clock   (clock),
      .reset   (reset),
      .key_n   (key_n[i]),
      .key_held(key_held[i])
    );
  end

  // Outputs are decoded from the next state so nothing reaches them combinationally.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      mask         <= '0;
      hold_cnt     <= '0;
      key          <= '0;
      key_strobe   <= 1'b0;
      chord_active <= 1'b0;
      long_press   <= 1'b0;
    end else begin
      key          <= '0;
      key_strobe   <= 1'b0;
      chord_active <= 1'b0;
      long_press   <= 1'b0;
      case (state)
        IDLE: begin
          if (key_held != '0) begin
            state        <= CHORD;
            mask         <= key_held;
            hold_cnt     <= '0;
            chord_active <= 1'b1;
          end
        end
        CHORD: begin
          mask     <= mask | key_held;
          hold_cnt <= hold_cnt + 1'b1;
          // Release is checked first so a release on the limit cycle still emits.
          if (key_held == '0) begin
            state      <= EMIT;
            key        <= mask;
            key_strobe <= 1'b1;
          end else if (hold_cnt == HOLD_LAST) begin
            state      <= WAIT_RELEASE;
            long_press <= 1'b1;
            mask       <= '0;
          end else begin
            chord_active <= 1'b1;
          end
        end
        EMIT: begin
          mask  <= '0;
          state <= IDLE;
        end
        WAIT_RELEASE: begin
          if (key_held == '0) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_chord_conditioner.sv
// Scoreboard bench for key_chord_conditioner with short debounce and hold limits.
module tb_key_chord_conditioner;

  localparam int NK = 4;
  localparam int DB = 4;
  localparam int MH = 20;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [NK-1:0] key_n = '1;
  logic [NK-1:0] key;
  logic          key_strobe;
  logic [NK-1:0] key_held;
  logic          chord_active;
  logic          long_press;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int lp_expect = 0;
  int lp_ref = 0;
  int nz_cycles = 0;
  logic [NK-1:0] exp_q[$];

  key_chord_conditioner #(
    .NUM_KEYS(NK),
    .DEBOUNCE_CYCLES(DB),
    .MAX_HOLD_CYCLES(MH)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .key_n       (key_n),
    .key         (key),
    .key_strobe  (key_strobe),
    .key_held    (key_held),
    .chord_active(chord_active),
    .long_press  (long_press)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Output monitor: every emitted code must match the oldest expected chord.
  always @(negedge clock) begin
    if (key != '0 || key_strobe) begin
      nz_cycles++;
      if (exp_q.size() > 0) check("chord_code", {27'd0, key_strobe, key}, {27'd0, 1'b1, exp_q.pop_front()});
      else check("spurious_strobe", {27'd0, key_strobe, key}, 32'd0);
    end
    if (long_press) begin
      if (lp_expect > 0) begin
        check("long_press_cycle", cyc - lp_ref, 27);
        lp_expect--;
      end else check("spurious_long_press", {31'd0, long_press}, 32'd0);
    end
  end

  initial begin
    int nz0;
    step(3);
    reset = 1'b0;
    @(negedge clock);
    check("reset_state", {key, key_strobe, key_held, chord_active, long_press}, 0);

    // Idle: nothing pressed
    for (int i = 0; i < 10; i++) begin
      step(1);
      @(negedge clock);
      check("idle_quiet", {key, key_strobe, key_held, chord_active}, 0);
    end

    // Single press of KEY0
    exp_q.push_back(4'h1);
    step(1);
    key_n = 4'hE;
    step(5);
    @(negedge clock);
    check("held_before_latency", key_held, 4'h0);
    step(1);
    @(negedge clock);
    check("held_at_latency", key_held, 4'h1);
    step(3);
    @(negedge clock);
    check("chord_active_single", chord_active, 1);
    step(4);
    key_n = 4'hF;
    step(20);
    check("single_drained", exp_q.size(), 0);
    check("single_idle", {key_held, chord_active}, 0);

    // Bounce on KEY2: 2-cycle pulses never survive debounce
    for (int i = 0; i < 5; i++) begin
      key_n[2] = 1'b0;
      step(2);
      key_n[2] = 1'b1;
      step(1);
      @(negedge clock);
      check("bounce_held", key_held, 4'h0);
      step(1);
    end
    step(10);
    check("bounce_no_chord", chord_active, 0);

    // Staggered four-key chord, released in reverse order
    nz0 = nz_cycles;
    exp_q.push_back(4'hF);
    key_n = 4'hE; step(1);
    key_n = 4'hC; step(1);
    key_n = 4'h8; step(1);
    key_n = 4'h0; step(10);
    @(negedge clock);
    check("chord_held_all", key_held, 4'hF);
    step(1);
    key_n = 4'h8; step(1);
    key_n = 4'hC; step(1);
    key_n = 4'hE; step(1);
    key_n = 4'hF; step(20);
    check("chord_drained", exp_q.size(), 0);
    check("chord_nz_cycles", nz_cycles - nz0, 1);

    // Over-long hold on KEY3, then a normal KEY1 press
    step(1);
    key_n = 4'h7;
    lp_ref = cyc;
    lp_expect = 1;
    step(27);
    @(negedge clock);
    check("long_abort_state", {key_held, chord_active}, {4'h8, 1'b0});
    step(3);
    key_n = 4'hF;
    step(12);
    check("long_press_seen", lp_expect, 0);
    check("long_no_strobe", exp_q.size(), 0);
    exp_q.push_back(4'h2);
    key_n = 4'hD;
    step(8);
    key_n = 4'hF;
    step(15);
    check("after_long_drained", exp_q.size(), 0);

    // Reset in the middle of a chord discards it
    key_n = 4'hE;
    for (int i = 0; i < 20 && !chord_active; i++) @(negedge clock);
    check("mid_chord_entered", chord_active, 1);
    step(1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    key_n = 4'hF;
    @(negedge clock);
    check("post_reset_outputs", {key, key_strobe, key_held, chord_active, long_press}, 0);
    step(15);
    check("post_reset_quiet", {key_held, chord_active}, 0);
    check("final_sb_empty", exp_q.size(), 0);
    check("final_lp_empty", lp_expect, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
